mem_arbiter: RTL and testbench

Two-port arbiter that shares the single word-granular external memory between the instruction cache and the data cache. Each cache sees a private copy of the external memory interface. The arbiter buffers one request per port, issues at most one transaction to memory at a time, and routes the response back to the port that owns it. It sits between the two cache instances and the top-level memory port.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one word-granular external memory between the instruction cache and
// the data cache. Each port owns a one-entry request latch; the arbiter
// launches at most one memory transaction at a time and routes the response
// back to the port that issued it.
//
// Parameters:
//   FIXED_PRIO  0 = round-robin on ties, 1 = data port always wins ties
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_ic_ren/i_ic_wen            instruction port read/write request
//   i_ic_addr/i_ic_wdata         instruction port word address / write data
//   o_ic_ready                   instruction port latch is empty
//   o_ic_rdata/o_ic_valid        instruction port response data / strobe
//   i_dc_* / o_dc_*              same set for the data port
//   i_mem_ready                  memory accepts a request this cycle
//   o_mem_addr/o_mem_wdata       registered memory address / write data
//   o_mem_ren/o_mem_wen          registered single-cycle memory strobes
//   i_mem_rdata/i_mem_valid      memory response data / strobe (reads and writes)

module mem_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ic_ren,
    input  logic        i_ic_wen,
    input  logic [31:0] i_ic_addr,
    input  logic [31:0] i_ic_wdata,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_addr,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_IC = 2'd1;
    localparam logic [1:0] ST_WAIT_DC = 2'd2;

    localparam bit DC_WINS_TIES = (FIXED_PRIO != 0);

    logic [1:0]  state;
    logic        last_dc;

    logic        ic_full;
    logic        ic_is_write;
    logic [31:0] ic_addr;
    logic [31:0] ic_wdata;

    logic        dc_full;
    logic        dc_is_write;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;

    logic        grant;
    logic        pick_dc;
    logic        win_write;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    assign o_ic_ready = !ic_full;
    assign o_dc_ready = !dc_full;

    // A new transaction may launch in the same cycle the previous response
    // arrives, which gives back-to-back strobes with no idle cycle between.
    assign grant = i_mem_ready && (ic_full || dc_full)
                   && ((state == ST_IDLE) || i_mem_valid);

    // last_dc resets to 0 (instruction port granted last), so the first tie
    // goes to the data port in both priority modes.
    assign pick_dc = dc_full && (!ic_full || DC_WINS_TIES || !last_dc);

    assign win_write = pick_dc ? dc_is_write : ic_is_write;
    assign win_addr  = pick_dc ? dc_addr     : ic_addr;
    assign win_wdata = pick_dc ? dc_wdata    : ic_wdata;

    // Responses are steered by the outstanding-owner state; a stray valid in
    // IDLE matches neither port and is dropped.
    assign o_ic_valid = i_mem_valid && (state == ST_WAIT_IC);
    assign o_dc_valid = i_mem_valid && (state == ST_WAIT_DC);
    assign o_ic_rdata = i_mem_rdata;
    assign o_dc_rdata = i_mem_rdata;

    // Instruction request latch. Capture only happens while empty and the
    // grant only clears it while full, so the two never collide. ren+wen
    // together is latched as a write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ic_full     <= 1'b0;
            ic_is_write <= 1'b0;
            ic_addr     <= '0;
            ic_wdata    <= '0;
        end else if (!ic_full && (i_ic_ren || i_ic_wen)) begin
            ic_full     <= 1'b1;
            ic_is_write <= i_ic_wen;
            ic_addr     <= i_ic_addr;
            ic_wdata    <= i_ic_wdata;
        end else if (grant && !pick_dc) begin
            ic_full     <= 1'b0;
        end
    end

    // Data request latch, same behaviour as the instruction latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dc_full     <= 1'b0;
            dc_is_write <= 1'b0;
            dc_addr     <= '0;
            dc_wdata    <= '0;
        end else if (!dc_full && (i_dc_ren || i_dc_wen)) begin
            dc_full     <= 1'b1;
            dc_is_write <= i_dc_wen;
            dc_addr     <= i_dc_addr;
            dc_wdata    <= i_dc_wdata;
        end else if (grant && pick_dc) begin
            dc_full     <= 1'b0;
        end
    end

    // Ownership FSM and registered memory request. Strobes are pulses that
    // only fire in the cycle after a grant; address and data hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            last_dc     <= 1'b0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (grant) begin
            state       <= pick_dc ? ST_WAIT_DC : ST_WAIT_IC;
            last_dc     <= pick_dc;
            o_mem_ren   <= !win_write;
            o_mem_wen   <= win_write;
            o_mem_addr  <= win_addr;
            o_mem_wdata <= win_wdata;
        end else begin
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            if (i_mem_valid || (state != ST_WAIT_IC && state != ST_WAIT_DC)) begin
                state   <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Lane 0 instantiates the round-robin variant and
// lane 1 the fixed-priority variant. Each lane has a memory responder with a
// programmable latency and a response monitor that pops expected read data
// from per-port scoreboard queues filled when requests are driven.
`timescale 1ns/1ps

module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ic_ren[2], ic_wen[2], ic_ready[2], ic_valid[2];
    logic [31:0] ic_addr[2], ic_wdata[2], ic_rdata[2];
    logic        dc_ren[2], dc_wen[2], dc_ready[2], dc_valid[2];
    logic [31:0] dc_addr[2], dc_wdata[2], dc_rdata[2];
    logic        mem_ready[2], mem_ren[2], mem_wen[2], mem_valid[2];
    logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

    int   mem_lat[2];
    logic pend[2];
    int   ic_resp[2], dc_resp[2];
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        lane;
        logic        we;
        logic [31:0] addr;
    } iss_t;
    iss_t iss_q[$];

    logic [31:0] q_ic0[$], q_dc0[$], q_ic1[$], q_dc1[$];

    // Contents of the modelled external memory.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void push_exp(input int lane, input bit dc, input logic [31:0] d);
        case ({lane[0], dc})
            2'b00:   q_ic0.push_back(d);
            2'b01:   q_dc0.push_back(d);
            2'b10:   q_ic1.push_back(d);
            default: q_dc1.push_back(d);
        endcase
    endfunction

    function automatic bit pop_exp(input int lane, input bit dc, output logic [31:0] d);
        d = '0;
        case ({lane[0], dc})
            2'b00:   if (q_ic0.size() > 0) begin d = q_ic0.pop_front(); return 1'b1; end
            2'b01:   if (q_dc0.size() > 0) begin d = q_dc0.pop_front(); return 1'b1; end
            2'b10:   if (q_ic1.size() > 0) begin d = q_ic1.pop_front(); return 1'b1; end
            default: if (q_dc1.size() > 0) begin d = q_dc1.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int exp_pending(input int lane);
        if (lane == 0) return q_ic0.size() + q_dc0.size();
        return q_ic1.size() + q_dc1.size();
    endfunction

    function automatic void flush_exp();
        q_ic0.delete(); q_dc0.delete(); q_ic1.delete(); q_dc1.delete();
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        int          cnt;
        logic [31:0] paddr;
        logic [31:0] exp_d;
        iss_t        e;

        mem_arbiter #(.FIXED_PRIO(g)) dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_ic_ren   (ic_ren[g]),
            .i_ic_wen   (ic_wen[g]),
            .i_ic_addr  (ic_addr[g]),
            .i_ic_wdata (ic_wdata[g]),
            .o_ic_ready (ic_ready[g]),
            .o_ic_rdata (ic_rdata[g]),
            .o_ic_valid (ic_valid[g]),
            .i_dc_ren   (dc_ren[g]),
            .i_dc_wen   (dc_wen[g]),
            .i_dc_addr  (dc_addr[g]),
            .i_dc_wdata (dc_wdata[g]),
            .o_dc_ready (dc_ready[g]),
            .o_dc_rdata (dc_rdata[g]),
            .o_dc_valid (dc_valid[g]),
            .i_mem_ready(mem_ready[g]),
            .o_mem_addr (mem_addr[g]),
            .o_mem_ren  (mem_ren[g]),
            .o_mem_wen  (mem_wen[g]),
            .o_mem_wdata(mem_wdata[g]),
            .i_mem_rdata(mem_rdata[g]),
            .i_mem_valid(mem_valid[g])
        );

        // Memory responder: answers each strobe mem_lat cycles later and
        // logs every issued transaction. Reset does not cancel a pending
        // answer, which is how the stray-valid case is produced.
        initial begin
            pend[g]      = 1'b0;
            mem_valid[g] = 1'b0;
            mem_rdata[g] = '0;
            cnt          = 0;
            paddr        = '0;
            forever begin
                @(posedge clk);
                #1;
                mem_valid[g] = 1'b0;
                if (pend[g]) begin
                    cnt--;
                    if (cnt <= 0) begin
                        mem_valid[g] = 1'b1;
                        mem_rdata[g] = mem_data(paddr);
                        pend[g]      = 1'b0;
                    end
                end
                if (mem_ren[g] || mem_wen[g]) begin
                    checks++;
                    if (pend[g] || (mem_ren[g] && mem_wen[g])) begin
                        errors++;
                        $display("[TB] FAIL one_outstanding lane%0d: ren=%b wen=%b pending=%b, required one strobe and none pending",
                                 g, mem_ren[g], mem_wen[g], pend[g]);
                    end
                    e.lane = 1'(g);
                    e.we   = mem_wen[g];
                    e.addr = mem_addr[g];
                    iss_q.push_back(e);
                    pend[g] = 1'b1;
                    cnt     = mem_lat[g];
                    paddr   = mem_addr[g];
                end
            end
        end

        // Response monitor: every port valid must match the next expected
        // response of that port.
        initial begin
            forever begin
                @(negedge clk);
                if (ic_valid[g] === 1'b1 && dc_valid[g] === 1'b1) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL both_valid lane%0d: ic_valid=1 dc_valid=1, required at most one", g);
                end
                if (ic_valid[g] === 1'b1) begin
                    checks++;
                    if (!pop_exp(g, 1'b0, exp_d)) begin
                        errors++;
                        $display("[TB] FAIL ic_resp lane%0d: unexpected ic_valid rdata=%h, required no response", g, ic_rdata[g]);
                    end else if (ic_rdata[g] !== exp_d) begin
                        errors++;
                        $display("[TB] FAIL ic_resp lane%0d: rdata=%h, required %h", g, ic_rdata[g], exp_d);
                    end
                    ic_resp[g]++;
                end
                if (dc_valid[g] === 1'b1) begin
                    checks++;
                    if (!pop_exp(g, 1'b1, exp_d)) begin
                        errors++;
                        $display("[TB] FAIL dc_resp lane%0d: unexpected dc_valid rdata=%h, required no response", g, dc_rdata[g]);
                    end else if (dc_rdata[g] !== exp_d) begin
                        errors++;
                        $display("[TB] FAIL dc_resp lane%0d: rdata=%h, required %h", g, dc_rdata[g], exp_d);
                    end
                    dc_resp[g]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post_req(input int d, input bit dc, input bit we,
                            input logic [31:0] a, input logic [31:0] wd);
        if (dc) begin
            dc_ren[d] = !we; dc_wen[d] = we; dc_addr[d] = a; dc_wdata[d] = wd;
        end else begin
            ic_ren[d] = !we; ic_wen[d] = we; ic_addr[d] = a; ic_wdata[d] = wd;
        end
        push_exp(d, dc, mem_data(a));
    endtask

    task automatic clear_req(input int d, input bit dc);
        if (dc) begin dc_ren[d] = 1'b0; dc_wen[d] = 1'b0; end
        else    begin ic_ren[d] = 1'b0; ic_wen[d] = 1'b0; end
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            clear_req(d, 1'b0); clear_req(d, 1'b1); mem_ready[d] = 1'b1;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        flush_exp();
        iss_q.delete();
    endtask

    task automatic wait_strobe(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ren[d] || mem_wen[d]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int d, input bit dc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((dc ? dc_valid[d] : ic_valid[d]) === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_drain(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_pending(d) == 0 && !pend[d]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            clear_req(d, 1'b0); clear_req(d, 1'b1); mem_ready[d] = 1'b1;
        end
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ic_ready[d] !== 1'b1 || dc_ready[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_ready lane%0d: ic_ready=%b dc_ready=%b, required 1 1", d, ic_ready[d], dc_ready[d]);
            end
            checks++;
            if (mem_ren[d] !== 1'b0 || mem_wen[d] !== 1'b0 || mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_mem lane%0d: ren=%b wen=%b addr=%h wdata=%h, required 0 0 0 0",
                         d, mem_ren[d], mem_wen[d], mem_addr[d], mem_wdata[d]);
            end
        end
        tick();
        rst = 1'b0;
        flush_exp();
        iss_q.delete();
    endtask

    task automatic test_single_read();
        do_reset();
        mem_lat[0] = 2;
        tick();
        post_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        clear_req(0, 1'b1);
        @(negedge clk);
        checks++;
        if (dc_ready[0] !== 1'b0 || mem_ren[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sr_cycle2: dc_ready=%b mem_ren=%b, required 0 0", dc_ready[0], mem_ren[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_ren[0] !== 1'b1 || mem_wen[0] !== 1'b0 || mem_addr[0] !== 32'h100) begin
            errors++;
            $display("[TB] FAIL sr_strobe: ren=%b wen=%b addr=%h, required 1 0 00000100", mem_ren[0], mem_wen[0], mem_addr[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dc_valid[0] !== 1'b0 || mem_ren[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sr_cycle4: dc_valid=%b mem_ren=%b, required 0 0", dc_valid[0], mem_ren[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dc_valid[0] !== 1'b1 || dc_rdata[0] !== 32'hDEAD_BEEF || ic_valid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sr_resp: dc_valid=%b rdata=%h ic_valid=%b, required 1 deadbeef 0",
                     dc_valid[0], dc_rdata[0], ic_valid[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dc_ready[0] !== 1'b1 || dc_valid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sr_after: dc_ready=%b dc_valid=%b, required 1 0", dc_ready[0], dc_valid[0]);
        end
    endtask

    task automatic test_write();
        bit ok;
        do_reset();
        mem_lat[0] = 1;
        tick();
        post_req(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
        tick();
        clear_req(0, 1'b0);
        wait_strobe(0, ok);
        checks++;
        if (!ok || mem_wen[0] !== 1'b1 || mem_ren[0] !== 1'b0 || mem_addr[0] !== 32'h20 || mem_wdata[0] !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL wr_strobe: seen=%b wen=%b ren=%b addr=%h wdata=%h, required 1 1 0 00000020 12345678",
                     ok, mem_wen[0], mem_ren[0], mem_addr[0], mem_wdata[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_wen[0] !== 1'b0 || ic_valid[0] !== 1'b1 || dc_valid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_ack: wen=%b ic_valid=%b dc_valid=%b, required 0 1 0", mem_wen[0], ic_valid[0], dc_valid[0]);
        end
    endtask

    task automatic test_tie_rr();
        bit          ok;
        iss_t        e;
        logic [31:0] order[3];
        order[0] = 32'h40; order[1] = 32'h0; order[2] = 32'h44;
        do_reset();
        mem_lat[0] = 3;
        tick();
        post_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        post_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        clear_req(0, 1'b0);
        clear_req(0, 1'b1);
        wait_strobe(0, ok);
        checks++;
        if (!ok || mem_addr[0] !== 32'h40) begin
            errors++;
            $display("[TB] FAIL rr_first: seen=%b addr=%h, required 1 00000040", ok, mem_addr[0]);
        end
        tick();
        post_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
        tick();
        clear_req(0, 1'b1);
        wait_valid(0, 1'b1, ok);
        tick();
        @(negedge clk);
        checks++;
        if (!ok || mem_ren[0] !== 1'b1 || mem_addr[0] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rr_b2b: dc_resp_seen=%b ren=%b addr=%h, required 1 1 00000000", ok, mem_ren[0], mem_addr[0]);
        end
        wait_drain(0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL rr_drain: responses outstanding=%0d, required 0", exp_pending(0));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (iss_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rr_order[%0d]: no transaction, required addr %h", i, order[i]);
            end else begin
                e = iss_q.pop_front();
                if (e.addr !== order[i]) begin
                    errors++;
                    $display("[TB] FAIL rr_order[%0d]: addr=%h, required %h", i, e.addr, order[i]);
                end
            end
        end
    endtask

    task automatic test_stream_fixed();
        bit   ok;
        iss_t e;
        int   ni, nd, base_i, base_d;
        ni = 0; nd = 0;
        do_reset();
        mem_lat[1] = 2;
        base_i = ic_resp[1];
        base_d = dc_resp[1];
        for (int c = 0; c < 300 && ((ic_resp[1] - base_i) < 4 || (dc_resp[1] - base_d) < 4); c++) begin
            tick();
            if (ic_ready[1] === 1'b1 && ni < 4) begin
                post_req(1, 1'b0, 1'b0, 32'h200 + 32'(4 * ni), 32'h0);
                ni++;
            end else begin
                clear_req(1, 1'b0);
            end
            if (dc_ready[1] === 1'b1 && nd < 4) begin
                post_req(1, 1'b1, 1'b0, 32'h300 + 32'(4 * nd), 32'h0);
                nd++;
            end else begin
                clear_req(1, 1'b1);
            end
        end
        clear_req(1, 1'b0);
        clear_req(1, 1'b1);
        wait_drain(1, ok);
        checks++;
        if (!ok || (ic_resp[1] - base_i) != 4 || (dc_resp[1] - base_d) != 4) begin
            errors++;
            $display("[TB] FAIL fp_count: ic=%0d dc=%0d, required 4 4", ic_resp[1] - base_i, dc_resp[1] - base_d);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] want;
            want = (i < 4) ? 32'h300 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 4));
            checks++;
            if (iss_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL fp_order[%0d]: no transaction, required addr %h", i, want);
            end else begin
                e = iss_q.pop_front();
                if (e.addr !== want || e.lane !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL fp_order[%0d]: lane=%b addr=%h, required 1 %h", i, e.lane, e.addr, want);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        mem_lat[0] = 2;
        mem_ready[0] = 1'b0;
        tick();
        post_req(0, 1'b0, 1'b0, 32'h80, 32'h0);
        post_req(0, 1'b1, 1'b0, 32'h84, 32'h0);
        tick();
        clear_req(0, 1'b0);
        clear_req(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_ren[0] !== 1'b0 || mem_wen[0] !== 1'b0 || ic_ready[0] !== 1'b0 || dc_ready[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: ren=%b wen=%b ic_ready=%b dc_ready=%b, required 0 0 0 0",
                         i, mem_ren[0], mem_wen[0], ic_ready[0], dc_ready[0]);
            end
            tick();
        end
        mem_ready[0] = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (mem_ren[0] !== 1'b1 || mem_addr[0] !== 32'h84) begin
            errors++;
            $display("[TB] FAIL bp_release: ren=%b addr=%h, required 1 00000084", mem_ren[0], mem_addr[0]);
        end
        wait_drain(0, ok);
        checks++;
        if (!ok || iss_q.size() != 2 || iss_q[1].addr !== 32'h80) begin
            errors++;
            $display("[TB] FAIL bp_drain: done=%b issued=%0d, required 1 2 with ic 00000080 second", ok, iss_q.size());
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit stray;
        stray = 1'b0;
        do_reset();
        mem_lat[0] = 4;
        tick();
        post_req(0, 1'b1, 1'b0, 32'h180, 32'h0);
        tick();
        clear_req(0, 1'b1);
        wait_strobe(0, ok);
        checks++;
        if (!ok || mem_addr[0] !== 32'h180) begin
            errors++;
            $display("[TB] FAIL rst_issue: seen=%b addr=%h, required 1 00000180", ok, mem_addr[0]);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush_exp();
        iss_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_valid[0] === 1'b1) stray = 1'b1;
            checks++;
            if (dc_valid[0] !== 1'b0 || ic_valid[0] !== 1'b0 || mem_ren[0] !== 1'b0 || mem_wen[0] !== 1'b0 ||
                mem_addr[0] !== 32'h0 || mem_wdata[0] !== 32'h0 || ic_ready[0] !== 1'b1 || dc_ready[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rst_quiet[%0d]: dc_v=%b ic_v=%b ren=%b wen=%b addr=%h wdata=%h rdy=%b%b, required 0 0 0 0 0 0 11",
                         i, dc_valid[0], ic_valid[0], mem_ren[0], mem_wen[0], mem_addr[0], mem_wdata[0], ic_ready[0], dc_ready[0]);
            end
            tick();
        end
        checks++;
        if (!stray) begin
            errors++;
            $display("[TB] FAIL rst_stray: stray mem_valid seen=0, required 1");
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ic_ren[d] = 1'b0; ic_wen[d] = 1'b0; ic_addr[d] = '0; ic_wdata[d] = '0;
            dc_ren[d] = 1'b0; dc_wen[d] = 1'b0; dc_addr[d] = '0; dc_wdata[d] = '0;
            mem_ready[d] = 1'b1;
            mem_lat[d]   = 2;
            ic_resp[d]   = 0;
            dc_resp[d]   = 0;
        end
        test_reset();
        test_single_read();
        test_write();
        test_tie_rr();
        test_stream_fixed();
        test_backpressure();
        test_reset_midop();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
